// File: rtl/equiv_stim_driver.sv
// LFSR stimulus driver and y_1/y_2 comparator for an equivalence pair. Each tag reaches the compare point COMPARE_LAT cycles after issue.
// No backpressure: one vector per cycle in RUN. Defining EQUIV_STOP_ON_FAIL_EN halts vector issue on the first mismatch seen in RUN.
module equiv_stim_driver #(
    parameter int          NUM_VECTORS = 1024,
    parameter int          CNT_W       = 16,
    parameter logic [88:0] SEED        = 89'h1,
    parameter int          COMPARE_LAT = 1,
    parameter int          Y_W         = 91
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [18:0]      wire0,
    output logic [16:0]      wire1,
    output logic [8:0]       wire2,
    output logic [19:0]      wire3,
    output logic [20:0]      wire4,
    input  logic [Y_W-1:0]   y_1,
    input  logic [Y_W-1:0]   y_2,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] fail_index,
    output logic [Y_W-1:0]   fail_y1,
    output logic [Y_W-1:0]   fail_y2
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // An all-zero seed would lock the LFSR up.
    localparam logic [88:0]      SEED_EFF   = (SEED == '0) ? 89'h1 : SEED;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] NUM_CNT    = CNT_W'(NUM_VECTORS);
    localparam logic [3:0]       DRAIN_LAST = 4'(COMPARE_LAT - 1);

    state_t           state;
    logic [88:0]      lfsr;
    logic [3:0]       drain_cnt;
    logic             tag_vld [COMPARE_LAT];
    logic [CNT_W-1:0] tag_idx [COMPARE_LAT];
    logic             mismatch;
    logic             stop_hit;
    logic             issue;

    assign mismatch = tag_vld[COMPARE_LAT-1] && (y_1 != y_2);
`ifdef EQUIV_STOP_ON_FAIL_EN
    assign stop_hit = (state == RUN) && mismatch && !fail;
`else
    assign stop_hit = 1'b0;
`endif
    assign issue = (state == RUN) && !stop_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            drain_cnt  <= '0;
            wire0      <= '0;
            wire1      <= '0;
            wire2      <= '0;
            wire3      <= '0;
            wire4      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            vec_count  <= '0;
            fail_index <= '0;
            fail_y1    <= '0;
            fail_y2    <= '0;
            for (int i = 0; i < COMPARE_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_idx[0] <= vec_count;
            for (int i = 1; i < COMPARE_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end

            if (mismatch && !fail) begin
                fail       <= 1'b1;
                fail_index <= tag_idx[COMPARE_LAT-1];
                fail_y1    <= y_1;
                fail_y2    <= y_2;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        lfsr       <= SEED_EFF;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        vec_count  <= '0;
                        fail_index <= '0;
                        fail_y1    <= '0;
                        fail_y2    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        wire0 <= lfsr[18:0];
                        wire1 <= lfsr[35:19];
                        wire2 <= lfsr[44:36];
                        wire3 <= lfsr[64:45];
                        wire4 <= lfsr[85:65];
                        lfsr  <= {lfsr[87:0], lfsr[88] ^ lfsr[37]};
                        if (vec_count != NUM_CNT)
                            vec_count <= vec_count + 1'b1;
                        if (vec_count == LAST_IDX) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // The last issued tag leaves the pipe after exactly COMPARE_LAT cycles.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_equiv_stim_driver.sv
// Bench for equiv_stim_driver: three instances (16 vec/lat 1, 1 vec/lat 8, 40 vec/lat 3 non-default seed).
module tb_equiv_stim_driver;
    localparam int          Y_W    = 91;
    localparam int          NA     = 16;
    localparam int          NC     = 40;
    localparam logic [88:0] SEED_C = 89'h1_2345_6789_ABCD_EF01_2345_67;
`ifdef EQUIV_STOP_ON_FAIL_EN
    localparam int STOP_CNT  = 4;
    localparam int STOP_BUSY = 6;
`else
    localparam int STOP_CNT  = 16;
    localparam int STOP_BUSY = 17;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;

    logic [18:0] w0_a, w0_b, w0_c;
    logic [16:0] w1_a, w1_b, w1_c;
    logic [8:0]  w2_a, w2_b, w2_c;
    logic [19:0] w3_a, w3_b, w3_c;
    logic [20:0] w4_a, w4_b, w4_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, fail_a, fail_b, fail_c;
    logic [15:0] cnt_a, cnt_b, cnt_c, fidx_a, fidx_b, fidx_c;
    logic [Y_W-1:0] fy1_a, fy2_a, fy1_b, fy2_b, fy1_c, fy2_c;
    logic [Y_W-1:0] y1_a, y2_a, y1_b, y2_b, y1_c, y2_c;
    logic [85:0] vec_a, vec_b, vec_c, d1_c = '0, d2_c = '0;
    logic        inj_a, inj_c;

    logic [85:0] exp_a [NA];
    logic [85:0] exp_c [NC];
    logic [85:0] exp_b0;
    logic [85:0] sb [$];

    always #5 clk = ~clk;

    assign vec_a = {w4_a, w3_a, w2_a, w1_a, w0_a};
    assign vec_b = {w4_b, w3_b, w2_b, w1_b, w0_b};
    assign vec_c = {w4_c, w3_c, w2_c, w1_c, w0_c};

    // Copy A: combinational DUT; copy 2 flips bit 0 on selected vector indices.
    always_comb begin
        inj_a = 1'b0;
        for (int k = 0; k < NA; k++)
            if (vec_a == exp_a[k] && ((mode_a == 1 && k == 5) || (mode_a == 2 && k >= 3)))
                inj_a = 1'b1;
    end
    assign y1_a = {5'b0, vec_a};
    assign y2_a = y1_a ^ {90'b0, inj_a};
    assign y1_b = {5'b0, vec_b};
    assign y2_b = y1_b;

    // Copy C: two-register DUT so y lines up with a COMPARE_LAT of 3.
    always @(posedge clk) begin
        d1_c <= vec_c;
        d2_c <= d1_c;
    end
    assign inj_c = (d2_c == exp_c[NC-1]);
    assign y1_c  = {5'b0, d2_c};
    assign y2_c  = y1_c ^ {90'b0, inj_c};

    equiv_stim_driver #(.NUM_VECTORS(NA), .CNT_W(16), .SEED(89'h1), .COMPARE_LAT(1), .Y_W(Y_W)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .wire0(w0_a), .wire1(w1_a), .wire2(w2_a), .wire3(w3_a), .wire4(w4_a),
        .y_1(y1_a), .y_2(y2_a), .busy(busy_a), .done(done_a), .fail(fail_a),
        .vec_count(cnt_a), .fail_index(fidx_a), .fail_y1(fy1_a), .fail_y2(fy2_a));

    equiv_stim_driver #(.NUM_VECTORS(1), .CNT_W(16), .SEED(89'h1), .COMPARE_LAT(8), .Y_W(Y_W)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .wire0(w0_b), .wire1(w1_b), .wire2(w2_b), .wire3(w3_b), .wire4(w4_b),
        .y_1(y1_b), .y_2(y2_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .vec_count(cnt_b), .fail_index(fidx_b), .fail_y1(fy1_b), .fail_y2(fy2_b));

    equiv_stim_driver #(.NUM_VECTORS(NC), .CNT_W(16), .SEED(SEED_C), .COMPARE_LAT(3), .Y_W(Y_W)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .wire0(w0_c), .wire1(w1_c), .wire2(w2_c), .wire3(w3_c), .wire4(w4_c),
        .y_1(y1_c), .y_2(y2_c), .busy(busy_c), .done(done_c), .fail(fail_c),
        .vec_count(cnt_c), .fail_index(fidx_c), .fail_y1(fy1_c), .fail_y2(fy2_c));

    function automatic logic [88:0] lfsr_next(input logic [88:0] s);
        return {s[87:0], s[88] ^ s[37]};
    endfunction

    // Runs copy A from start to done, scoring every new vector; pulses start again at loop step mid.
    task automatic run_a(input int mid, output int busy_cyc);
        int          last;
        bit          fin;
        logic [85:0] exp;
        sb.delete();
        for (int k = 0; k < NA; k++) sb.push_back(exp_a[k]);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        busy_cyc = 0;
        last = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            start_a = (c == mid);
            if (int'(cnt_a) != last) begin
                last = int'(cnt_a);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL a_vec_extra: count=%0d with empty scoreboard", last);
                end else begin
                    exp = sb.pop_front();
                    if (vec_a !== exp) begin
                        errors++;
                        $display("FAIL a_vec[%0d]: got %h want %h", last - 1, vec_a, exp);
                    end
                end
            end
            if (busy_a) busy_cyc++;
            if (done_a) fin = 1'b1;
            else @(negedge clk);
        end
        start_a = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: done got 0 want 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vec_a, vec_b, vec_c} !== '0) begin
            errors++; $display("FAIL reset_wires: got %h %h %h want 0", vec_a, vec_b, vec_c);
        end
        checks++;
        if ({busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c} !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0", {busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c});
        end
        checks++;
        if ({cnt_a, fidx_a, cnt_b, fidx_b, cnt_c, fidx_c} !== '0) begin
            errors++; $display("FAIL reset_counts: got %h want 0", {cnt_a, fidx_a, cnt_b, fidx_b, cnt_c, fidx_c});
        end
        checks++;
        if ({fy1_a, fy2_a, fy1_b, fy2_b, fy1_c, fy2_c} !== '0) begin
            errors++; $display("FAIL reset_captures: nonzero want 0");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int bc;
        mode_a = 0;
        run_a(-1, bc);
        checks++;
        if (bc != 17) begin errors++; $display("FAIL basic_busy: got %0d want 17", bc); end
        checks++;
        if ({done_a, fail_a} !== 2'b10) begin errors++; $display("FAIL basic_flags: done,fail got %b want 10", {done_a, fail_a}); end
        checks++;
        if (cnt_a !== 16'd16) begin errors++; $display("FAIL basic_count: got %0d want 16", cnt_a); end
        checks++;
        if (vec_a !== exp_a[NA-1]) begin errors++; $display("FAIL basic_hold: got %h want %h", vec_a, exp_a[NA-1]); end
    endtask

    task automatic test_single_mismatch();
        int bc;
        mode_a = 1;
        run_a(-1, bc);
        checks++;
        if ({fail_a, fidx_a} !== {1'b1, 16'd5}) begin errors++; $display("FAIL single_idx: fail,index got %b,%0d want 1,5", fail_a, fidx_a); end
        checks++;
        if (fy1_a !== {5'b0, exp_a[5]}) begin errors++; $display("FAIL single_y1: got %h want %h", fy1_a, {5'b0, exp_a[5]}); end
        checks++;
        if (fy2_a !== (fy1_a ^ 91'd1)) begin errors++; $display("FAIL single_y2: got %h want %h", fy2_a, fy1_a ^ 91'd1); end
        checks++;
        if (cnt_a !== 16'd16) begin errors++; $display("FAIL single_count: got %0d want 16", cnt_a); end
    endtask

    task automatic test_stop_on_fail();
        int bc;
        mode_a = 2;
        run_a(-1, bc);
        checks++;
        if ({fail_a, fidx_a} !== {1'b1, 16'd3}) begin errors++; $display("FAIL stop_idx: fail,index got %b,%0d want 1,3", fail_a, fidx_a); end
        checks++;
        if (int'(cnt_a) != STOP_CNT) begin errors++; $display("FAIL stop_count: got %0d want %0d", cnt_a, STOP_CNT); end
        checks++;
        if (bc != STOP_BUSY) begin errors++; $display("FAIL stop_busy: got %0d want %0d", bc, STOP_BUSY); end
        checks++;
        if (fy1_a !== {5'b0, exp_a[3]}) begin errors++; $display("FAIL stop_y1: got %h want %h", fy1_a, {5'b0, exp_a[3]}); end
    endtask

    task automatic test_reset_mid_run();
        int bc;
        mode_a = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (fail_a !== 1'b1) begin errors++; $display("FAIL midrst_pre: fail got %b want 1", fail_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_a, busy_a, done_a, fail_a, cnt_a, fidx_a} !== '0) begin
            errors++; $display("FAIL midrst_async: got %h want 0", {vec_a, busy_a, done_a, fail_a, cnt_a, fidx_a});
        end
        checks++;
        if ({fy1_a, fy2_a} !== '0) begin errors++; $display("FAIL midrst_captures: got %h want 0", {fy1_a, fy2_a}); end
        @(negedge clk);
        rst_n = 1'b1;
        mode_a = 0;
        run_a(-1, bc);
        checks++;
        if ({bc, fail_a, cnt_a} !== {32'd17, 1'b0, 16'd16}) begin
            errors++; $display("FAIL midrst_rerun: busy,fail,count got %0d,%b,%0d want 17,0,16", bc, fail_a, cnt_a);
        end
    endtask

    task automatic test_start_ignored();
        int bc;
        mode_a = 0;
        run_a(5, bc);
        checks++;
        if ({bc, cnt_a} !== {32'd17, 16'd16}) begin errors++; $display("FAIL ign_run: busy,count got %0d,%0d want 17,16", bc, cnt_a); end
        run_a(16, bc);
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, cnt_a} !== {2'b10, 16'd16}) begin
            errors++; $display("FAIL ign_done_entry: done,busy,count got %b,%b,%0d want 1,0,16", done_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_restart_from_done();
        int bc;
        bit fin;
        mode_a = 2;
        run_a(-1, bc);
        checks++;
        if (fail_a !== 1'b1) begin errors++; $display("FAIL restart_pre: fail got %b want 1", fail_a); end
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if ({busy_a, done_a, fail_a, cnt_a, fidx_a} !== {3'b100, 32'd0}) begin
            errors++; $display("FAIL restart_clear: busy,done,fail,count,index got %b%b%b,%0d,%0d want 100,0,0", busy_a, done_a, fail_a, cnt_a, fidx_a);
        end
        fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (done_a) fin = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if ({fin, fail_a, cnt_a} !== {2'b10, 16'd16}) begin
            errors++; $display("FAIL restart_run: done,fail,count got %b,%b,%0d want 1,0,16", fin, fail_a, cnt_a);
        end
    endtask

    task automatic test_single_vector();
        int bc;
        bit fin;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        bc = 0;
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (busy_b) bc++;
            if (done_b) fin = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!fin || bc != 9) begin errors++; $display("FAIL nv1_busy: done %b busy cycles got %0d want 9", fin, bc); end
        checks++;
        if ({cnt_b, fail_b} !== {16'd1, 1'b0}) begin errors++; $display("FAIL nv1_count: count,fail got %0d,%b want 1,0", cnt_b, fail_b); end
        checks++;
        if (vec_b !== exp_b0) begin errors++; $display("FAIL nv1_vec: got %h want %h", vec_b, exp_b0); end
    endtask

    task automatic test_last_vector_mismatch();
        int          bc;
        int          last;
        bit          fin;
        logic [85:0] exp;
        sb.delete();
        for (int k = 0; k < NC; k++) sb.push_back(exp_c[k]);
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        bc = 0;
        last = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (int'(cnt_c) != last) begin
                last = int'(cnt_c);
                checks++;
                exp = (sb.size() != 0) ? sb.pop_front() : 86'd0;
                if (vec_c !== exp) begin errors++; $display("FAIL c_vec[%0d]: got %h want %h", last - 1, vec_c, exp); end
            end
            if (busy_c) bc++;
            if (done_c) fin = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!fin || bc != 43) begin errors++; $display("FAIL c_busy: done %b busy cycles got %0d want 43", fin, bc); end
        checks++;
        if ({fail_c, fidx_c, cnt_c} !== {1'b1, 16'd39, 16'd40}) begin
            errors++; $display("FAIL c_last: fail,index,count got %b,%0d,%0d want 1,39,40", fail_c, fidx_c, cnt_c);
        end
        checks++;
        if ({fy1_c, fy2_c} !== {{5'b0, exp_c[NC-1]}, {5'b0, exp_c[NC-1]} ^ 91'd1}) begin
            errors++; $display("FAIL c_captures: y1 %h y2 %h want y1 %h", fy1_c, fy2_c, {5'b0, exp_c[NC-1]});
        end
    endtask

    initial begin
        logic [88:0] s;
        s = 89'h1;
        exp_b0 = s[85:0];
        for (int k = 0; k < NA; k++) begin
            exp_a[k] = s[85:0];
            s = lfsr_next(s);
        end
        s = SEED_C;
        for (int k = 0; k < NC; k++) begin
            exp_c[k] = s[85:0];
            s = lfsr_next(s);
        end
        test_reset();
        test_basic();
        test_single_mismatch();
        test_stop_on_fail();
        test_reset_mid_run();
        test_start_ignored();
        test_restart_from_done();
        test_single_vector();
        test_last_vector_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/equiv_stim_driver.md
Name: equiv_stim_driver

Overview:
- Drives the five input buses of an equivalence pair (two DUT copies fed identical inputs, outputs y_1/y_2) with pseudo-random vectors from an LFSR.
- Checks y_1 against y_2 after a fixed DUT latency and captures the first mismatch.
- Reports pass/fail and progress to the fuzz harness, replacing free-running formal stimulus in simulation and FPGA regression runs.

Parameters:
- NUM_VECTORS, 1024, number of vectors applied per run (1..2^CNT_W-1)
- CNT_W, 16, width of the vector counter and index outputs
- SEED, 89'h1, LFSR seed loaded on reset and on start; a value of 0 is replaced by 1
- COMPARE_LAT, 1, cycles from the vector appearing on wire* to the corresponding y_1/y_2 being comparable (1..8)
- Y_W, 91, width of y_1/y_2

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle or done
- wire0  out  19  stimulus to both DUTs
- wire1  out  17  stimulus to both DUTs
- wire2  out  9  stimulus to both DUTs
- wire3  out  20  stimulus to both DUTs
- wire4  out  21  stimulus to both DUTs
- y_1  in  Y_W  output of DUT copy 1
- y_2  in  Y_W  output of DUT copy 2
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE until the next start
- fail  out  1  sticky mismatch flag, cleared on start
- vec_count  out  CNT_W  vectors applied this run
- fail_index  out  CNT_W  index of the first mismatching vector
- fail_y1  out  Y_W  y_1 captured at the first mismatch
- fail_y2  out  Y_W  y_2 captured at the first mismatch

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; LFSR=SEED.
  - All wire* = 0; busy=done=fail=0; vec_count=fail_index=0; fail_y1=fail_y2=0.
- LFSR:
  - 89-bit Fibonacci, polynomial x^89+x^38+1; next = {s[87:0], s[88]^s[37]}.
  - Advances exactly once per applied vector.
- Vector mapping, registered from the current LFSR state:
  - wire0=s[18:0], wire1=s[35:19], wire2=s[44:36], wire3=s[64:45], wire4=s[85:65].
- FSM: IDLE -> RUN -> DRAIN -> DONE.
  - IDLE/DONE + start: reload LFSR=SEED, clear vec_count/fail/fail_index/fail_y*, go RUN, done=0.
  - RUN: every cycle drives the next vector onto wire*, increments vec_count and pushes valid into a COMPARE_LAT-deep tag pipe (valid + index). After vector NUM_VECTORS-1 is issued, go DRAIN.
  - DRAIN: wire* hold the last vector. Go DONE once the tag pipe is empty (exactly COMPARE_LAT cycles).
  - DONE: busy=0, done=1; wire* hold the last vector.
  - start while busy is ignored.
- Compare:
  - When the tag-pipe tail is valid and y_1 != y_2, a mismatch is detected.
  - If fail is 0: set fail=1 and latch fail_index=tail index, fail_y1=y_1, fail_y2=y_2.
  - Later mismatches do not update the captured fields.
- Boundaries:
  - NUM_VECTORS=1: RUN lasts one cycle.
  - vec_count saturates at NUM_VECTORS.
  - A mismatch on the last vector is detected in DRAIN, before DONE.
  - Reset mid-run aborts to IDLE with all outputs reset. No partial results are kept.
  - start on the same cycle as DONE entry is seen only from the following cycle.

Optional Feature:
- Macro: EQUIV_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in RUN, stop issuing vectors (LFSR and vec_count frozen, wire* hold) and go DRAIN, then DONE. Mismatches still in the pipe are ignored.
- Undefined: the run always completes all NUM_VECTORS vectors; fail stays sticky.

Test Plan:
- Reset held 3 cycles, release, start, y_2 tied to y_1 (COMPARE_LAT=1, NUM_VECTORS=16) -> busy for 17 cycles, done=1, fail=0, vec_count=16; first vector wire0=19'h1, other buses 0.
- Same run with y_2 = y_1 ^ 1 only while the tail index is 5 -> fail=1, fail_index=5, fail_y2=fail_y1^1, vec_count=16.
- Persistent mismatch from index 3 with EQUIV_STOP_ON_FAIL_EN defined -> fail_index=3, vec_count=4, done after COMPARE_LAT drain cycles; undefined -> vec_count=16, fail_index still 3.
- rst_n asserted on cycle 7 of RUN, then a new start -> all outputs 0 asynchronously; the new run reproduces the identical vector sequence from SEED.
- start pulsed during RUN and during DONE -> the first is ignored; the second restarts with fail and vec_count cleared.
- NUM_VECTORS=1, COMPARE_LAT=8 -> RUN 1 cycle, DRAIN 8 cycles, then done.
